router_out_arbiter: RTL

Round-robin output arbiter for the router's per-input packet FIFOs. It watches the `rempty` flags of NPORTS packet FIFOs, grants one non-empty FIFO and walks its byte-addressed read port (`raddr_in`) through header, payload and CRC. Each byte goes onto a single output link with valid/ready flow control, then the arbiter pops the packet with a one-cycle `rinc`. It sits in the read-clock domain, between the FIFO bank and the output link.

---
 rtl/router_pkg.sv | 23 ++
 rtl/rr_picker.sv | 32 +++
 rtl/router_out_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet byte offsets, arbiter FSM states
// and default datapath sizes.
package router_pkg;

    localparam int SRC_OFS  = 0;
    localparam int DST_OFS  = 1;
    localparam int SIZE_OFS = 2;
    localparam int HDR_LEN  = 3;
    localparam int OVERHEAD = 4;

    localparam int DEF_UWIDTH    = 8;
    localparam int DEF_WIDTH     = 11;
    localparam int DEF_PTR_IN_SZ = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        POP,
        SETTLE
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot winner among the requests,
// scanning upward from the port after last_i.
module rr_picker
    import router_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0]         req_i,
    input  logic [$clog2(NPORTS)-1:0] last_i,
    output logic [NPORTS-1:0]         gnt_o
);

    localparam int LW = $clog2(NPORTS);

    logic          found;
    logic [LW-1:0] pos;

    // First requester at or after last+1, wrapping modulo NPORTS
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            pos = LW'((int'(last_i) + i) % NPORTS);
            if (!found && req_i[pos]) begin
                gnt_o[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Output arbiter: grants one non-empty packet FIFO, streams its bytes
// to the output link, then pops it. Optional ARB_LEN_CHECK_EN drops oversized packets.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int UWIDTH    = DEF_UWIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_IN_SZ = DEF_PTR_IN_SZ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        rempty,
    input  logic [NPORTS*UWIDTH-1:0] rdata,
    output logic [PTR_IN_SZ-1:0]     raddr_in,
    output logic [NPORTS-1:0]        rinc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [UWIDTH-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [NPORTS-1:0]        grant
`ifdef ARB_LEN_CHECK_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int LW   = $clog2(NPORTS);
    localparam int LENW = PTR_IN_SZ + 1;
    localparam logic [UWIDTH-1:0] MAX_SIZE = UWIDTH'(WIDTH - OVERHEAD);

    arb_state_e state_q, state_d;

    logic [NPORTS-1:0]    grant_q, grant_d;
    logic [LW-1:0]        last_q, last_d;
    logic [PTR_IN_SZ-1:0] idx_q, idx_d;
    logic [LENW-1:0]      len_q, len_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic [UWIDTH-1:0]    data_q, data_d;

    logic [NPORTS-1:0]    req;
    logic [NPORTS-1:0]    pick;
    logic [NPORTS-1:0]    sel;
    logic [LW-1:0]        gidx;
    logic [UWIDTH-1:0]    byte_in;
    logic [UWIDTH-1:0]    size_cl;
    logic [LENW-1:0]      len_new;
    logic                 at_size;
    logic                 oversize;
    logic                 last_byte;
    logic                 drop;
    logic                 eop_now;
    logic                 accept;
    logic                 ld;

`ifdef ARB_LEN_CHECK_EN
    logic [7:0]           drop_q, drop_d;
`endif

    assign req = ~rempty;

    rr_picker #(
        .NPORTS (NPORTS)
    ) u_picker (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Byte source: the picker's winner during GRANT, the owner afterwards
    always_comb begin
        sel     = (state_q == GRANT) ? pick : grant_q;
        byte_in = '0;
        gidx    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (sel[p]) begin
                byte_in = byte_in | rdata[p*UWIDTH +: UWIDTH];
            end
            if (grant_q[p]) begin
                gidx = LW'(p);
            end
        end
    end

    // Classify the byte at idx: length field, last byte, oversize drop
    always_comb begin
        at_size   = (idx_q == PTR_IN_SZ'(SIZE_OFS));
        oversize  = (byte_in > MAX_SIZE);
        size_cl   = oversize ? MAX_SIZE : byte_in;
        len_new   = LENW'(size_cl) + LENW'(OVERHEAD);
        last_byte = (idx_q >= PTR_IN_SZ'(HDR_LEN)) &&
                    ({1'b0, idx_q} == len_q - LENW'(1));
`ifdef ARB_LEN_CHECK_EN
        drop      = at_size && oversize;
`else
        drop      = 1'b0;
`endif
        eop_now   = last_byte || drop;
    end

    assign accept = valid_q && out_ready;
    assign ld = ((state_q == GRANT) && (|pick)) ||
                ((state_q == SEND) && (!valid_q || out_ready) && !eop_q);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   state_d = (|pick) ? SEND : IDLE;
            SEND:    if (accept && eop_q) state_d = POP;
            POP:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rinc      = (state_q == POP) ? grant_q : '0;
        grant     = grant_q;
        raddr_in  = idx_q;
        out_valid = valid_q;
        out_data  = data_q;
        out_sop   = sop_q;
        out_eop   = eop_q;
    end

    // Datapath next state: byte load, length latch, grant and last
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        idx_d   = idx_q;
        len_d   = len_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
`ifdef ARB_LEN_CHECK_EN
        drop_d  = drop_q;
        if (ld && drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
`endif
        if (ld) begin
            valid_d = 1'b1;
            data_d  = byte_in;
            sop_d   = (idx_q == PTR_IN_SZ'(SRC_OFS));
            eop_d   = eop_now;
            idx_d   = eop_now ? idx_q : idx_q + PTR_IN_SZ'(1);
            if (at_size) begin
                len_d = len_new;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
        if (state_q == GRANT) begin
            grant_d = pick;
        end
        if (state_q == POP) begin
            last_d = gidx;
            idx_d  = '0;
        end
        if (state_q == SETTLE) begin
            grant_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            last_q  <= LW'(NPORTS - 1);
            idx_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

`ifdef ARB_LEN_CHECK_EN
    // Saturating count of dropped packets
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule
